// File: rtl/insnmem_responder.sv
// Instruction-memory responder: synchronous-read instruction array, fixed-latency
// response pipeline and a credit-protected response FIFO with flush and program-load port.
module insnmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int INSN_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [INSN_WIDTH-1:0] resp_insn,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  input  logic                  resp_stall,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [INSN_WIDTH-1:0] wr_data
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + LATENCY + 1);

  logic [INSN_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic [LATENCY-1:0]    pipe_valid;
  logic [ADDR_WIDTH-1:0] pipe_addr [LATENCY];
  logic [INSN_WIDTH-1:0] pipe_insn [LATENCY];

  logic [INSN_WIDTH-1:0] fifo_insn [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [OCC_W-1:0]      occ;

  logic [INSN_WIDTH-1:0] hold_insn;
  logic [ADDR_WIDTH-1:0] hold_addr;

  logic [CNT_W-1:0] outstanding;
  logic             accept;
  logic             push;
  logic             pop;

  // Credit counts every in-flight stage plus buffered entries; a same-cycle pop is
  // deliberately ignored so req_ready never depends on resp_stall.
  always_comb begin
    outstanding = CNT_W'(occ);
    for (int i = 0; i < LATENCY; i++) begin
      outstanding = outstanding + CNT_W'(pipe_valid[i]);
    end
    req_ready  = !rst && !flush && (outstanding < CNT_W'(FIFO_DEPTH));
    accept     = req_valid && req_ready;
    push       = pipe_valid[LATENCY-1] && !flush;
    resp_valid = (occ != '0);
    pop        = resp_valid && !resp_stall;
    resp_insn  = resp_valid ? fifo_insn[rd_ptr] : hold_insn;
    resp_addr  = resp_valid ? fifo_addr[rd_ptr] : hold_addr;
  end

  // Storage and data paths carry no reset; validity is tracked separately below.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    pipe_insn[0] <= mem[req_addr];
    pipe_addr[0] <= req_addr;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_insn[i] <= pipe_insn[i-1];
      pipe_addr[i] <= pipe_addr[i-1];
    end
    if (push) begin
      fifo_insn[wr_ptr] <= pipe_insn[LATENCY-1];
      fifo_addr[wr_ptr] <= pipe_addr[LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      hold_insn  <= '0;
      hold_addr  <= '0;
    end else begin
      if (resp_valid) begin
        hold_insn <= fifo_insn[rd_ptr];
        hold_addr <= fifo_addr[rd_ptr];
      end
      if (flush) begin
        pipe_valid <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        occ        <= '0;
      end else begin
        pipe_valid[0] <= accept;
        for (int i = 1; i < LATENCY; i++) begin
          pipe_valid[i] <= pipe_valid[i-1];
        end
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   occ <= occ + OCC_W'(1);
          2'b01:   occ <= occ - OCC_W'(1);
          default: occ <= occ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_insnmem_responder.sv
// Scoreboard bench for insnmem_responder: accepted fetches are queued with their
// expected word and acceptance cycle, then matched against the response stream.
module tb_insnmem_responder;

  localparam int ADDR_WIDTH = 8;
  localparam int INSN_WIDTH = 32;
  localparam int LATENCY    = 2;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [INSN_WIDTH-1:0] insn;
    int                    t;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  req_valid = 1'b0;
  logic [ADDR_WIDTH-1:0] req_addr = '0;
  logic                  req_ready;
  logic                  resp_valid;
  logic [INSN_WIDTH-1:0] resp_insn;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic                  resp_stall = 1'b0;
  logic                  flush = 1'b0;
  logic                  wr_en = 1'b0;
  logic [ADDR_WIDTH-1:0] wr_addr = '0;
  logic [INSN_WIDTH-1:0] wr_data = '0;

  logic [INSN_WIDTH-1:0] model_mem [2**ADDR_WIDTH];
  exp_t                  sb [$];
  logic [INSN_WIDTH-1:0] last_insn = '0;
  logic [ADDR_WIDTH-1:0] last_addr = '0;
  int                    cycle = 0;
  int                    checks = 0;
  int                    errors = 0;

  insnmem_responder #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .INSN_WIDTH(INSN_WIDTH),
    .LATENCY   (LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_insn (resp_insn),
    .resp_addr (resp_addr),
    .resp_stall(resp_stall),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic logic [INSN_WIDTH-1:0] initWord(input int i);
    if (i < 4) return INSN_WIDTH'(32'h11 * (i + 1));
    if (i == 5) return 32'h55;
    return 32'hC000_0000 | INSN_WIDTH'(i * 32'h0101);
  endfunction

  // Sample at the falling edge, update the model, then step past the next rising edge.
  task automatic stepCycle();
    exp_t e;
    logic exp_valid;
    @(negedge clk);
    checkOutput("req_ready", 64'(req_ready), 64'(!flush && (sb.size() < FIFO_DEPTH)));
    exp_valid = (sb.size() != 0) && (cycle >= sb[0].t + LATENCY + 1);
    checkOutput("resp_valid", 64'(resp_valid), 64'(exp_valid));
    if (exp_valid) begin
      e = sb[0];
      checkOutput("resp_addr", 64'(resp_addr), 64'(e.addr));
      checkOutput("resp_insn", 64'(resp_insn), 64'(e.insn));
      last_insn = e.insn;
      last_addr = e.addr;
      if (!resp_stall) void'(sb.pop_front());
    end else begin
      checkOutput("hold_insn", 64'(resp_insn), 64'(last_insn));
      checkOutput("hold_addr", 64'(resp_addr), 64'(last_addr));
    end
    if (flush) sb.delete();
    if (req_valid && req_ready) begin
      e.addr = req_addr;
      e.insn = model_mem[req_addr];
      e.t    = cycle;
      sb.push_back(e);
    end
    if (wr_en) model_mem[wr_addr] = wr_data;
    cycle++;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [ADDR_WIDTH-1:0] ra, input logic st,
                               input logic fl, input logic we, input logic [ADDR_WIDTH-1:0] wa,
                               input logic [INSN_WIDTH-1:0] wd);
    req_valid  = rv;
    req_addr   = ra;
    resp_stall = st;
    flush      = fl;
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    stepCycle();
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, st, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("rst_resp_insn", 64'(resp_insn), 64'(0));
    checkOutput("rst_resp_addr", 64'(resp_addr), 64'(0));

    for (int i = 0; i < 2**ADDR_WIDTH; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = ADDR_WIDTH'(i);
      wr_data = initWord(i);
      model_mem[i] = initWord(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back fetches, no stall
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, ADDR_WIDTH'(i), 1'b0, 1'b0, 1'b0, '0, '0);
    idle(6, 1'b0);

    // Held stall: credit stops at FIFO_DEPTH outstanding
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, ADDR_WIDTH'(i % 4), 1'b1, 1'b0, 1'b0, '0, '0);
    idle(8, 1'b0);

    // Flush with one buffered and two in flight, then a fresh fetch of addr 3
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, ADDR_WIDTH'(i), 1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b1, 1'b0, '0, '0);
    applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(6, 1'b0);

    // Read-before-write on the same address
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 8'd5, 32'hAA);
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(6, 1'b0);

    // Asynchronous reset with three outstanding fetches
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, ADDR_WIDTH'(i + 1), 1'b1, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("midrst_req_ready", 64'(req_ready), 64'(0));
    checkOutput("midrst_resp_insn", 64'(resp_insn), 64'(0));
    sb.delete();
    last_insn = '0;
    last_addr = '0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    idle(5, 1'b0);
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(5, 1'b0);

    // Randomised traffic against the scoreboard
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), ADDR_WIDTH'($urandom_range(0, 2**ADDR_WIDTH - 1)),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0),
                    1'($urandom_range(0, 15) == 0), ADDR_WIDTH'($urandom_range(0, 2**ADDR_WIDTH - 1)),
                    INSN_WIDTH'($urandom));
    end
    idle(12, 1'b0);
    checkOutput("drain_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
